// File: rtl/gate_bist_pkg.sv
// Shared definitions for the logic-gate BIST checker:
// FSM states, gate_out bit map, vector table, reference model.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int unsigned GB_NOT  = 6;
   localparam int unsigned GB_AND  = 5;
   localparam int unsigned GB_NAND = 4;
   localparam int unsigned GB_OR   = 3;
   localparam int unsigned GB_NOR  = 2;
   localparam int unsigned GB_XOR  = 1;
   localparam int unsigned GB_XNOR = 0;

   localparam int unsigned NUM_VEC = 4;
   localparam int unsigned RESP_W  = 7;

   // Entries are {A,B}, applied in index order
   localparam logic [1:0] VEC_TABLE [NUM_VEC] = '{
      2'b00, 2'b10, 2'b01, 2'b11
   };

   function automatic logic [RESP_W-1:0] expected_resp(
      input logic a,
      input logic b
   );
      logic [RESP_W-1:0] r;
      r          = '0;
      r[GB_NOT]  = ~a;
      r[GB_AND]  = a & b;
      r[GB_NAND] = ~(a & b);
      r[GB_OR]   = a | b;
      r[GB_NOR]  = ~(a | b);
      r[GB_XOR]  = a ^ b;
      r[GB_XNOR] = ~(a ^ b);
      return r;
   endfunction

endpackage

// File: rtl/gate_bist_checker.sv
// Truth-table BIST for a 2-input gate block: drives A/B, waits, compares.
// Ports: clk, rst (async high), start | in_a, in_b -> DUT, gate_out <- DUT
//        busy, done, pass, err_count, fail_mask, fail_bits (all registered)
module gate_bist_checker
   import gate_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        in_a,
   output logic        in_b,
   input  logic [6:0]  gate_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [2:0]  err_count,
   output logic [3:0]  fail_mask,
   output logic [6:0]  fail_bits
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        a_d, b_d;
   logic        busy_d, done_d, pass_d;
   logic [2:0]  err_d;
   logic [3:0]  mask_d;
   logic [6:0]  bits_d;
   logic [6:0]  diff;

   // Expected values come from the registered operands, so the
   // comparison always matches the vector currently on the DUT.
   assign diff = gate_out ^ expected_resp(in_a, in_b);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      a_d     = in_a;
      b_d     = in_b;
      pass_d  = pass;
      err_d   = err_count;
      mask_d  = fail_mask;
      bits_d  = fail_bits;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_SETTLE;
               cnt_d      = '0;
               idx_d      = '0;
               {a_d, b_d} = VEC_TABLE[0];
               pass_d     = 1'b0;
               err_d      = '0;
               mask_d     = '0;
               bits_d     = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CHECK: begin
            if (|diff) begin
               mask_d[idx_q] = 1'b1;
               err_d         = err_count + 3'd1;
               if (err_count == 3'd0) bits_d = diff;
            end
            if (idx_q == 2'd3) begin
               state_d = ST_DONE;
               pass_d  = (err_d == 3'd0);
            end else begin
               state_d    = ST_SETTLE;
               idx_d      = idx_q + 2'd1;
               {a_d, b_d} = VEC_TABLE[idx_q + 2'd1];
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         in_a      <= 1'b0;
         in_b      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_mask <= '0;
         fail_bits <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         in_a      <= a_d;
         in_b      <= b_d;
         busy      <= busy_d;
         done      <= done_d;
         pass      <= pass_d;
         err_count <= err_d;
         fail_mask <= mask_d;
         fail_bits <= bits_d;
      end
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker with a switchable faulty gate model
// and a queue of expected run results.
module tb_gate_bist_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_a, in_b;
   logic [6:0] gate_out;
   logic       busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   logic [6:0] fail_bits;

   int mode;
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [3:0] mask;
      logic [6:0] bits;
   } res_t;

   res_t sb[$];

   logic [1:0] vtab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

   always #5 clk = ~clk;

   gate_bist_checker #(.SETTLE_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_a      (in_a),
      .in_b      (in_b),
      .gate_out  (gate_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_mask (fail_mask),
      .fail_bits (fail_bits)
   );

   // Gate block under test: 0 good, 1 xor stuck-at-0, 2 not acting as buffer
   always_comb begin
      gate_out    = '0;
      gate_out[6] = ~in_a;
      gate_out[5] = in_a & in_b;
      gate_out[4] = ~(in_a & in_b);
      gate_out[3] = in_a | in_b;
      gate_out[2] = ~(in_a | in_b);
      gate_out[1] = in_a ^ in_b;
      gate_out[0] = ~(in_a ^ in_b);
      if (mode == 1) gate_out[1] = 1'b0;
      if (mode == 2) gate_out[6] = in_a;
   end

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, 16'(in_a), 16'd0);
      check({tag, "_b"}, 16'(in_b), 16'd0);
      check({tag, "_busy"}, 16'(busy), 16'd0);
      check({tag, "_done"}, 16'(done), 16'd0);
      check({tag, "_pass"}, 16'(pass), 16'd0);
      check({tag, "_err"}, 16'(err_count), 16'd0);
      check({tag, "_mask"}, 16'(fail_mask), 16'd0);
      check({tag, "_bits"}, 16'(fail_bits), 16'd0);
   endtask

   task automatic push(input logic p, input logic [2:0] e,
                       input logic [3:0] m, input logic [6:0] b);
      res_t r;
      r.pass = p;
      r.err  = e;
      r.mask = m;
      r.bits = b;
      sb.push_back(r);
   endtask

   // Caller is at a negedge; start is raised here for one cycle.
   // repulse>0 re-raises start for one cycle after that many edges.
   task automatic run(input int repulse);
      int   cyc;
      logic seen;
      res_t e;
      start = 1'b1;
      cyc   = 0;
      seen  = 1'b0;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) begin
            check("busy_rise", 16'(busy), 16'd1);
            check("pass_busy", 16'(pass), 16'd0);
         end
         if (cyc <= 10 && (cyc - 1) % 3 == 0)
            check("vector", 16'({in_a, in_b}), 16'(vtab[(cyc - 1) / 3]));
         if (done) seen = 1'b1;
         start = (cyc == repulse);
      end
      start = 1'b0;
      check("latency", 16'(cyc), 16'd13);
      check("busy_done", 16'(busy), 16'd0);
      check("ab_hold", 16'({in_a, in_b}), 16'b11);
      if (sb.size() == 0) begin
         check("sb_empty", 16'd1, 16'd0);
      end else begin
         e = sb.pop_front();
         check("pass", 16'(pass), 16'(e.pass));
         check("err_count", 16'(err_count), 16'(e.err));
         check("fail_mask", 16'(fail_mask), 16'(e.mask));
         check("fail_bits", 16'(fail_bits), 16'(e.bits));
      end
      @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 0;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // good gate block
      mode = 0;
      push(1'b1, 3'd0, 4'b0000, 7'b0000000);
      run(0);

      // xor stuck-at-0
      mode = 1;
      push(1'b0, 3'd2, 4'b0110, 7'b0000010);
      run(0);
      repeat (3) @(negedge clk);
      check("hold_done", 16'(done), 16'd1);
      check("hold_err", 16'(err_count), 16'd2);
      check("hold_mask", 16'(fail_mask), 16'b0110);

      // restart from DONE after failing run
      mode = 0;
      push(1'b1, 3'd0, 4'b0000, 7'b0000000);
      run(0);

      // not output behaving as buffer
      mode = 2;
      push(1'b0, 3'd4, 4'b1111, 7'b1000000);
      run(0);

      // start while busy is ignored
      mode = 0;
      push(1'b1, 3'd0, 4'b0000, 7'b0000000);
      run(5);

      // reset during vector 2 settle of a failing run
      mode  = 2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_ab", 16'({in_a, in_b}), 16'b01);
      check("pre_rst_err", 16'(err_count), 16'd2);
      #1;
      rst = 1'b1;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst  = 1'b0;
      mode = 0;
      push(1'b1, 3'd0, 4'b0000, 7'b0000000);
      run(0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
